bin_to_bcd_display: RTL and testbench
=====================================

// Module: bin_to_bcd_display
// PURPOSE
//   Sequential binary-to-BCD converter that feeds seven_segment_controller.
//   Converts an unsigned binary value to 8 BCD digits using shift-add-3 (double dabble), one bit per clock.
//   Generates digit-enable (leading-zero blanking) and decimal-point masks.
//   Outputs connect directly to the controller's digit/en_digit/en_dot inputs.
//   Outputs hold the last result, so the display stays steady during a new conversion.
// PARAMETERS
//   BIN_W   27   width of binary input; 2^27 covers 99_999_999
//   NDIG    8    number of BCD digits; fixed by the controller, only 8 supported
// PORTS
//   clk       in   1        system clock, rising edge
//   rst       in   1        asynchronous reset, active-low (asserted when 0)
//   start     in   1        request conversion; sampled only in IDLE
//   value     in   BIN_W    unsigned binary operand, latched when start is accepted
//   lzb       in   1        1 = blank leading zeros; latched with value
//   dp_en     in   1        1 = light one decimal point; latched with value
//   dp_pos    in   3        digit index of the decimal point (0 = rightmost); latched with value
//   busy      out  1        1 while a conversion is in progress
//   done      out  1        one-cycle pulse when new outputs become valid
//   ovf       out  1        1 = last value exceeded 99_999_999 and was saturated
//   digit     out  32       BCD digits; digit[4i+3:4i] = position i, i=0 is least significant
//   en_digit  out  8        bit i enables position i
//   en_dot    out  8        one-hot decimal-point mask; bit i = position i
// BEHAVIOUR
//   Reset values (rst=0, async): FSM=IDLE, busy=0, done=0, ovf=0, digit=0, en_digit=8'h01, en_dot=0.
//   FSM states: IDLE -> CONV -> FIN -> IDLE.
//   IDLE
//     - At a rising edge with start=1: latch value/lzb/dp_en/dp_pos.
//     - Clear the shift register and BCD accumulator; load the bit counter with BIN_W.
//     - Go to CONV; busy=1 after that edge.
//   CONV
//     - Each edge: every BCD nibble >=5 gets +3.
//     - Then shift {bcd, bin} left by one; decrement the counter.
//     - After exactly BIN_W edges, go to FIN.
//   FIN (one cycle)
//     - Register digit, en_digit, en_dot and ovf.
//     - done=1 and busy=0 for exactly this one cycle after the edge.
//     - Then return to IDLE.
//   Latency: start accepted at edge E0 -> outputs/done valid after edge E(BIN_W+1).
//     - Default parameters: 28 cycles.
//     - Back-to-back start in the cycle done is high is accepted.
//   Overflow
//     - Latched value > 99_999_999: digit=32'h99999999, ovf=1, conversion still takes full latency.
//     - Otherwise ovf=0.
//   en_digit
//     - lzb=0 -> 8'hFF.
//     - lzb=1 -> bits 0..k set, where k = max(index of highest nonzero digit, dp_pos if dp_en, 0).
//     - Position 0 is always lit; digits at or right of the decimal point are never blanked.
//   en_dot
//     - dp_en=1 -> 8'b1 << dp_pos.
//     - dp_en=0 -> 8'h00.
//   start while busy (CONV/FIN): ignored, no queueing; inputs changing during CONV have no effect.
//   digit/en_digit/en_dot/ovf change only on the FIN edge; they are never partial.
//   Reset mid-conversion: all state returns to reset values immediately; the pending result is discarded.
// TESTING
//   1. Reset: rst=0 -> digit=0, en_digit=8'h01, en_dot=0, busy=0, done=0.
//   2. value=12_345_678, lzb=1, dp_en=0 -> after 28 cycles: done pulse, digit=32'h12345678, en_digit=8'hFF, ovf=0.
//   3. value=0, lzb=1 -> digit=0, en_digit=8'h01; value=0, lzb=0 -> en_digit=8'hFF.
//   4. value=5, lzb=1, dp_en=1, dp_pos=2 -> digit=32'h00000005, en_digit=8'h07, en_dot=8'h04.
//   5. value=100_000_000 -> digit=32'h99999999, ovf=1; then value=9 -> digit=32'h00000009, ovf=0.
//   6. start=1 with value=42, then start=1 with value=7 at cycle 5 -> only 42 converted, a single done pulse.
//      Then rst=0 at cycle 10 of a new conversion -> no done, outputs return to reset values.

Source files
------------

// File: rtl/bin_to_bcd_display_if.sv
// rtl/bin_to_bcd_display_if.sv - request/result bundle between a client and bin_to_bcd_display
interface bin_to_bcd_display_if #(
  parameter int BIN_W = 27
) ();
  logic             start;
  logic [BIN_W-1:0] value;
  logic             lzb;
  logic             dp_en;
  logic [2:0]       dp_pos;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [31:0]      digit;
  logic [7:0]       en_digit;
  logic [7:0]       en_dot;

  modport master (
    output start, value, lzb, dp_en, dp_pos,
    input  busy, done, ovf, digit, en_digit, en_dot
  );

  modport slave (
    input  start, value, lzb, dp_en, dp_pos,
    output busy, done, ovf, digit, en_digit, en_dot
  );
endinterface

// File: rtl/bin_to_bcd_display.sv
// rtl/bin_to_bcd_display.sv - sequential double-dabble binary-to-BCD converter with display masks
module bin_to_bcd_display #(
  parameter int BIN_W = 27,
  parameter int NDIG  = 8
) (
  input  logic                clk,
  input  logic                rst,
  bin_to_bcd_display_if.slave bus
);

  localparam int                 DIG_W   = 4 * NDIG;
  localparam int                 CNT_W   = $clog2(BIN_W + 1);
  localparam int                 SH_W    = DIG_W + BIN_W;
  localparam logic [BIN_W-1:0]   MAX_VAL = BIN_W'(99_999_999);
  localparam logic [DIG_W-1:0]   SAT_BCD = {NDIG{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;

  // conversion working set
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [DIG_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lzb_q, lzb_d;
  logic               dp_en_q, dp_en_d;
  logic [2:0]         dp_pos_q, dp_pos_d;
  logic               sat_q, sat_d;

  // visible result, only rewritten on the FIN edge
  logic [DIG_W-1:0]   digit_q, digit_d;
  logic [7:0]         en_digit_q, en_digit_d;
  logic [7:0]         en_dot_q, en_dot_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [DIG_W-1:0]   bcd_adj;
  logic [SH_W-1:0]    shifted;
  logic [DIG_W-1:0]   res_digits;
  logic [2:0]         top_idx;
  logic [7:0]         blank_mask;
  logic [7:0]         en_digit_res;
  logic [7:0]         en_dot_res;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: IDLE waits for start, CONV runs BIN_W shifts, FIN lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CONV;
      S_CONV:  if (cnt_q == CNT_W'(1)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // add-3 correction on every nibble that would overflow past 9 after doubling
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  // display masks derived from the finished (possibly saturated) digits
  always_comb begin
    res_digits = sat_q ? SAT_BCD : bcd_q;
    top_idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (res_digits[4*i +: 4] != 4'h0) top_idx = 3'(i);
    end
    if (dp_en_q && (dp_pos_q > top_idx)) top_idx = dp_pos_q;
    for (int i = 0; i < 8; i++) begin
      blank_mask[i] = (3'(i) <= top_idx);
    end
    en_digit_res = lzb_q ? blank_mask : 8'hFF;
    en_dot_res   = dp_en_q ? (8'h01 << dp_pos_q) : 8'h00;
  end

  // datapath next values: latch on accept, shift in CONV, publish in FIN
  always_comb begin
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    lzb_d      = lzb_q;
    dp_en_d    = dp_en_q;
    dp_pos_d   = dp_pos_q;
    sat_d      = sat_q;
    digit_d    = digit_q;
    en_digit_d = en_digit_q;
    en_dot_d   = en_dot_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          bin_d    = bus.value;
          bcd_d    = '0;
          cnt_d    = CNT_W'(BIN_W);
          lzb_d    = bus.lzb;
          dp_en_d  = bus.dp_en;
          dp_pos_d = bus.dp_pos;
          sat_d    = (bus.value > MAX_VAL);
        end
      end
      S_CONV: begin
        bcd_d = shifted[SH_W-1:BIN_W];
        bin_d = shifted[BIN_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
      end
      S_FIN: begin
        digit_d    = res_digits;
        en_digit_d = en_digit_res;
        en_dot_d   = en_dot_res;
        ovf_d      = sat_q;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // datapath and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      lzb_q      <= 1'b0;
      dp_en_q    <= 1'b0;
      dp_pos_q   <= 3'd0;
      sat_q      <= 1'b0;
      digit_q    <= '0;
      en_digit_q <= 8'h01;
      en_dot_q   <= 8'h00;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      lzb_q      <= lzb_d;
      dp_en_q    <= dp_en_d;
      dp_pos_q   <= dp_pos_d;
      sat_q      <= sat_d;
      digit_q    <= digit_d;
      en_digit_q <= en_digit_d;
      en_dot_q   <= en_dot_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  // outputs: busy covers CONV and FIN, everything else is registered
  always_comb begin
    bus.busy     = (state_q != S_IDLE);
    bus.done     = done_q;
    bus.ovf      = ovf_q;
    bus.digit    = digit_q;
    bus.en_digit = en_digit_q;
    bus.en_dot   = en_dot_q;
  end

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// tb/tb_bin_to_bcd_display.sv - directed self-checking bench for bin_to_bcd_display
module tb_bin_to_bcd_display;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  bin_to_bcd_display_if #(.BIN_W(27)) bus ();

  bin_to_bcd_display #(.BIN_W(27), .NDIG(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a conversion and wait (bounded) for done; lat=0 means done never came.
  task automatic convert(input logic [26:0] v, input logic l, input logic de,
                         input logic [2:0] dp, output int lat, output logic stable);
    logic [31:0] prev;
    prev = bus.digit;
    stable = 1'b1;
    @(negedge clk);
    bus.value = v; bus.lzb = l; bus.dp_en = de; bus.dp_pos = dp; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.digit !== prev) stable = 1'b0;
    end
  endtask

  initial begin
    int   lat;
    logic stable;
    int   dones;

    n_chk = 0; n_fail = 0;
    bus.start = 1'b0; bus.value = '0; bus.lzb = 1'b0; bus.dp_en = 1'b0; bus.dp_pos = 3'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_digit", bus.digit, 32'h0);
    chk("rst_en_digit", {24'h0, bus.en_digit}, 32'h01);
    chk("rst_en_dot", {24'h0, bus.en_dot}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_ovf", {31'h0, bus.ovf}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // 12_345_678 with blanking, no dot
    convert(27'd12_345_678, 1'b1, 1'b0, 3'd0, lat, stable);
    chk("t2_latency", lat, 28);
    chk("t2_stable", {31'h0, stable}, 32'h1);
    chk("t2_digit", bus.digit, 32'h12345678);
    chk("t2_en_digit", {24'h0, bus.en_digit}, 32'hFF);
    chk("t2_en_dot", {24'h0, bus.en_dot}, 32'h00);
    chk("t2_ovf", {31'h0, bus.ovf}, 32'h0);
    chk("t2_busy", {31'h0, bus.busy}, 32'h0);
    @(negedge clk);
    chk("t2_done_pulse", {31'h0, bus.done}, 32'h0);
    chk("t2_hold", bus.digit, 32'h12345678);

    // zero, blanked and unblanked
    convert(27'd0, 1'b1, 1'b0, 3'd0, lat, stable);
    chk("t3a_digit", bus.digit, 32'h0);
    chk("t3a_en_digit", {24'h0, bus.en_digit}, 32'h01);
    convert(27'd0, 1'b0, 1'b0, 3'd0, lat, stable);
    chk("t3b_en_digit", {24'h0, bus.en_digit}, 32'hFF);

    // decimal point keeps digits to its right lit
    convert(27'd5, 1'b1, 1'b1, 3'd2, lat, stable);
    chk("t4_digit", bus.digit, 32'h00000005);
    chk("t4_en_digit", {24'h0, bus.en_digit}, 32'h07);
    chk("t4_en_dot", {24'h0, bus.en_dot}, 32'h04);

    // highest digit wins over a lower decimal point
    convert(27'd1000, 1'b1, 1'b1, 3'd1, lat, stable);
    chk("t4b_digit", bus.digit, 32'h00001000);
    chk("t4b_en_digit", {24'h0, bus.en_digit}, 32'h0F);
    chk("t4b_en_dot", {24'h0, bus.en_dot}, 32'h02);

    // overflow saturation and recovery, plus the exact upper limit
    convert(27'd100_000_000, 1'b1, 1'b0, 3'd0, lat, stable);
    chk("t5_latency", lat, 28);
    chk("t5_digit", bus.digit, 32'h99999999);
    chk("t5_ovf", {31'h0, bus.ovf}, 32'h1);
    convert(27'd9, 1'b1, 1'b0, 3'd0, lat, stable);
    chk("t5b_digit", bus.digit, 32'h00000009);
    chk("t5b_ovf", {31'h0, bus.ovf}, 32'h0);
    chk("t5b_en_digit", {24'h0, bus.en_digit}, 32'h01);
    convert(27'd99_999_999, 1'b1, 1'b0, 3'd0, lat, stable);
    chk("t5c_digit", bus.digit, 32'h99999999);
    chk("t5c_ovf", {31'h0, bus.ovf}, 32'h0);

    // start while busy is ignored; only 42 is converted
    @(negedge clk);
    bus.value = 27'd42; bus.lzb = 1'b0; bus.dp_en = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t6_busy", {31'h0, bus.busy}, 32'h1);
    dones = 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        bus.value = 27'd7; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        dones++;
        if (lat == 0) lat = k;
      end
    end
    bus.start = 1'b0;
    chk("t6_done_count", dones, 1);
    chk("t6_latency", lat, 28);
    chk("t6_digit", bus.digit, 32'h00000042);

    // back-to-back: start during the done cycle is accepted
    convert(27'd321, 1'b1, 1'b0, 3'd0, lat, stable);
    chk("t7a_digit", bus.digit, 32'h00000321);
    bus.value = 27'd654; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t7_busy", {31'h0, bus.busy}, 32'h1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    chk("t7_latency", lat, 28);
    chk("t7_digit", bus.digit, 32'h00000654);
    chk("t7_en_digit", {24'h0, bus.en_digit}, 32'h07);

    // reset in the middle of a conversion discards it
    @(negedge clk);
    bus.value = 27'd5555; bus.lzb = 1'b1; bus.dp_en = 1'b1; bus.dp_pos = 3'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t8_digit", bus.digit, 32'h0);
    chk("t8_en_digit", {24'h0, bus.en_digit}, 32'h01);
    chk("t8_en_dot", {24'h0, bus.en_dot}, 32'h0);
    chk("t8_busy", {31'h0, bus.busy}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("t8_no_done", dones, 0);
    chk("t8_digit_after", bus.digit, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
